// File: rtl/rr_arbiter8_pkg.sv
// +------------------------------------------------------------------+
// | arb_pkg : shared types and the round-robin search for rr_arbiter8 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_result_t;

   // Search begins just after `last` and wraps, so `last` itself is tried last.
   function automatic rr_result_t next_rr(input logic [N_REQ-1:0] req,
                                          input logic [IDX_W-1:0] last);
      rr_result_t       res;
      logic [IDX_W-1:0] j;
      res = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         j = last + IDX_W'(i);
         if (!res.found && req[j]) begin
            res.found = 1'b1;
            res.idx   = j;
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter8_if.sv
// +------------------------------------------------------------------+
// | rr_arbiter8_if : request/grant bundle between requesters and arb |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface rr_arbiter8_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             timeout;

   modport master (
      output req, done,
      input  grant, grant_idx, grant_valid, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_idx, grant_valid, timeout
   );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter8_decoder3x8.sv
// +------------------------------------------------------------------+
// | decoder3x8 : enabled 3-to-8 one-hot decoder                      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module decoder3x8
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] A,
   input  logic             En,
   output logic [N_REQ-1:0] Y
);

   assign Y = En ? (N_REQ'(1) << A) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// +------------------------------------------------------------------+
// | rr_arbiter8 : 8-way round-robin arbiter, optional ARB_TIMEOUT_EN  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic         clk,
   input  logic         rst,
   rr_arbiter8_if.slave bus
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD out of range 2..255");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic             timeout_q, timeout_d;
   logic             w_force;
   logic             w_release;
   rr_result_t       w_pick;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Forced release only when nothing else would release this edge anyway.
   assign w_force = (state_q == BUSY) && (cnt_q == CNT_W'(MAX_HOLD - 1))
                    && !bus.done && bus.req[idx_q];
`else
   assign w_force = 1'b0;
`endif

   assign w_release = bus.done || !bus.req[idx_q] || w_force;
   assign w_pick    = next_rr(bus.req, (state_q == BUSY) ? idx_q : last_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         last_q    <= IDX_W'(N_REQ - 1);
         timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (w_pick.found) begin
               state_d = BUSY;
               idx_d   = w_pick.idx;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         BUSY: begin
            if (w_release) begin
               last_d    = idx_q;
               timeout_d = w_force;
`ifdef ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
               if (w_pick.found) begin
                  idx_d = w_pick.idx;
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
               end
            end else begin
`ifdef ARB_TIMEOUT_EN
               if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = (state_q == BUSY);
   assign bus.timeout     = timeout_q;

   decoder3x8 u_dec (
      .A  (idx_q),
      .En (state_q == BUSY),
      .Y  (bus.grant)
   );

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// +------------------------------------------------------------------+
// | tb_rr_arbiter8 : directed self-checking bench for rr_arbiter8    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_rr_arbiter8;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   rr_arbiter8_if bus ();

   rr_arbiter8 #(.MAX_HOLD(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] g,
                            input logic [2:0] idx, input logic v,
                            input logic to);
      check_eq({tag, ".grant"}, 32'(bus.grant), 32'(g));
      check_eq({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
      check_eq({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
      check_eq({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
   endtask

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      rst      = 1'b1;
      bus.req  = 8'h00;
      bus.done = 1'b0;
      step();
      step();
      check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Basic grant, then done-driven rotation with no bubble.
      bus.req = 8'b0000_0101;
      step();
      check_out("first", 8'h01, 3'd0, 1'b1, 1'b0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check_out("done1", 8'h04, 3'd2, 1'b1, 1'b0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check_out("done2_wrap", 8'h01, 3'd0, 1'b1, 1'b0);

      // Back to holder 2, then it withdraws while 7 and 0 request.
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check_out("to_idx2", 8'h04, 3'd2, 1'b1, 1'b0);
      bus.req = 8'b1000_0001;
      step();
      check_out("withdraw", 8'h80, 3'd7, 1'b1, 1'b0);

      // Other bits changing while busy are ignored.
      bus.req = 8'b1000_0011;
      step();
      check_out("hold1", 8'h80, 3'd7, 1'b1, 1'b0);
      bus.req = 8'b1100_0011;
      step();
      check_out("hold2", 8'h80, 3'd7, 1'b1, 1'b0);

      // done plus a freshly asserted bit: pointer=7 so bit 0 wins over new 3.
      bus.req  = 8'b1100_1011;
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check_out("done_newreq", 8'h01, 3'd0, 1'b1, 1'b0);

      // Move to idx 3, then reset between edges.
      bus.req = 8'b0000_1000;
      step();
      check_out("to_idx3", 8'h08, 3'd3, 1'b1, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      bus.req = 8'hFF;
      step();
      check_out("in_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check_out("after_rst", 8'h01, 3'd0, 1'b1, 1'b0);

      // All requests drop at the release edge, then done in IDLE is ignored.
      bus.req = 8'h00;
      step();
      check_out("all_drop", 8'h00, 3'd0, 1'b0, 1'b0);
      bus.done = 1'b1;
      step();
      step();
      bus.done = 1'b0;
      check_out("idle_done", 8'h00, 3'd0, 1'b0, 1'b0);

      // Sole requester 7 with no done.
      bus.req = 8'b1000_0000;
      step();
      check_out("sole_c1", 8'h80, 3'd7, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
      for (int c = 2; c <= 4; c++) begin
         step();
         check_out($sformatf("sole_c%0d", c), 8'h80, 3'd7, 1'b1, 1'b0);
      end
      step();
      check_out("forced", 8'h80, 3'd7, 1'b1, 1'b1);
      step();
      check_out("pulse_end", 8'h80, 3'd7, 1'b1, 1'b0);
      step();
      step();
      check_out("restart_c4", 8'h80, 3'd7, 1'b1, 1'b0);
      step();
      check_out("forced2", 8'h80, 3'd7, 1'b1, 1'b1);
      // done coincides with the counter limit: normal release, no pulse.
      step();
      step();
      step();
      check_out("pre_limit", 8'h80, 3'd7, 1'b1, 1'b0);
      bus.req  = 8'b1000_0010;
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check_out("done_at_limit", 8'h02, 3'd1, 1'b1, 1'b0);
`else
      for (int c = 2; c <= 10; c++) step();
      check_out("held_long", 8'h80, 3'd7, 1'b1, 1'b0);
      bus.req = 8'b1000_0010;
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check_out("after_long", 8'h02, 3'd1, 1'b1, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
